// File: rtl/avmm_mon_bridge.sv
// Avalon-MM pipeline bridge (JTAG master -> CSR space) with a two-entry command buffer,
// an outstanding-read limit, saturating traffic statistics and a sticky read-timeout flag.
module avmm_mon_bridge #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 24,
    parameter int BURST_W     = 1,
    parameter int MAX_PENDING = 16,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset_n,
    input  logic [ADDR_W-1:0]                  s0_address,
    input  logic [BURST_W-1:0]                 s0_burstcount,
    input  logic [DATA_W-1:0]                  s0_writedata,
    input  logic [DATA_W/8-1:0]                s0_byteenable,
    input  logic                               s0_read,
    input  logic                               s0_write,
    input  logic                               s0_debugaccess,
    output logic                               s0_waitrequest,
    output logic [DATA_W-1:0]                  s0_readdata,
    output logic                               s0_readdatavalid,
    output logic [ADDR_W-1:0]                  m0_address,
    output logic [BURST_W-1:0]                 m0_burstcount,
    output logic [DATA_W-1:0]                  m0_writedata,
    output logic [DATA_W/8-1:0]                m0_byteenable,
    output logic                               m0_read,
    output logic                               m0_write,
    output logic                               m0_debugaccess,
    input  logic                               m0_waitrequest,
    input  logic [DATA_W-1:0]                  m0_readdata,
    input  logic                               m0_readdatavalid,
    input  logic                               stat_clr,
    output logic [CNT_W-1:0]                   stat_wr_beats,
    output logic [CNT_W-1:0]                   stat_rd_cmds,
    output logic [CNT_W-1:0]                   stat_rd_beats,
    output logic [$clog2(MAX_PENDING+1)-1:0]   stat_max_pending,
    output logic                               stat_timeout
);

    localparam int BE_W      = DATA_W / 8;
    localparam int MAX_BURST = 1 << (BURST_W - 1);
    localparam int PEND_W    = $clog2(MAX_PENDING + 1);
    localparam int SUM_W     = PEND_W + BURST_W + 1;
    localparam int IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SUM_W-1:0]  THRESH   = SUM_W'(MAX_PENDING - MAX_BURST);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

    typedef struct packed {
        logic [ADDR_W-1:0]  address;
        logic [BURST_W-1:0] burstcount;
        logic [DATA_W-1:0]  writedata;
        logic [BE_W-1:0]    byteenable;
        logic               read;
        logic               write;
        logic               debugaccess;
    } cmd_t;

    cmd_t               s0_cmd, out_q, skid_q;
    logic               skid_full, skid_full_nxt;
    logic               out_ready, accept, rd_accept, wr_accept;
    logic [BURST_W-1:0] bc_eff;
    logic [PEND_W-1:0]  pending;
    logic [SUM_W-1:0]   pend_sum, pend_nxt;
    logic               throttle_nxt;
    logic [IDLE_W-1:0]  idle_cnt, idle_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        s0_cmd = '{address: s0_address, burstcount: s0_burstcount, writedata: s0_writedata,
                   byteenable: s0_byteenable, read: s0_read, write: s0_write,
                   debugaccess: s0_debugaccess};
        accept    = (s0_read | s0_write) & ~s0_waitrequest;
        rd_accept = accept & s0_read;
        wr_accept = accept & s0_write;
        out_ready = ~(out_q.read | out_q.write) | ~m0_waitrequest;
        // Skid only ever fills behind a stalled output register, so it drains first.
        skid_full_nxt = skid_full ? ~out_ready : (accept & ~out_ready);

        bc_eff   = (s0_burstcount == '0) ? BURST_W'(1) : s0_burstcount;
        pend_sum = SUM_W'(pending) + (rd_accept ? SUM_W'(bc_eff) : '0);
        if (s0_readdatavalid && pend_sum != '0)
            pend_nxt = pend_sum - SUM_W'(1);
        else
            pend_nxt = pend_sum;
        throttle_nxt = pend_nxt > THRESH;

        if (stat_clr || pending == '0 || s0_readdatavalid)
            idle_nxt = '0;
        else if (idle_cnt != IDLE_MAX)
            idle_nxt = idle_cnt + IDLE_W'(1);
        else
            idle_nxt = idle_cnt;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            out_q            <= '0;
            skid_q           <= '0;
            skid_full        <= 1'b0;
            s0_waitrequest   <= 1'b1;
            pending          <= '0;
            s0_readdata      <= '0;
            s0_readdatavalid <= 1'b0;
            idle_cnt         <= '0;
            stat_wr_beats    <= '0;
            stat_rd_cmds     <= '0;
            stat_rd_beats    <= '0;
            stat_max_pending <= '0;
            stat_timeout     <= 1'b0;
        end else begin
            if (skid_full) begin
                if (out_ready) out_q <= skid_q;
            end else if (accept) begin
                if (out_ready) out_q  <= s0_cmd;
                else           skid_q <= s0_cmd;
            end else if (out_ready) begin
                out_q <= '0;
            end
            skid_full        <= skid_full_nxt;
            s0_waitrequest   <= skid_full_nxt | throttle_nxt;
            pending          <= pend_nxt[PEND_W-1:0];
            s0_readdata      <= m0_readdata;
            s0_readdatavalid <= m0_readdatavalid;
            idle_cnt         <= idle_nxt;

            if (stat_clr) begin
                stat_wr_beats    <= '0;
                stat_rd_cmds     <= '0;
                stat_rd_beats    <= '0;
                stat_max_pending <= '0;
                stat_timeout     <= 1'b0;
            end else begin
                stat_wr_beats <= sat_inc(stat_wr_beats, wr_accept);
                stat_rd_cmds  <= sat_inc(stat_rd_cmds, rd_accept);
                stat_rd_beats <= sat_inc(stat_rd_beats, s0_readdatavalid);
                if (pending > stat_max_pending) stat_max_pending <= pending;
                stat_timeout  <= stat_timeout | (idle_nxt == IDLE_MAX);
            end
        end
    end

    assign m0_address     = out_q.address;
    assign m0_burstcount  = out_q.burstcount;
    assign m0_writedata   = out_q.writedata;
    assign m0_byteenable  = out_q.byteenable;
    assign m0_read        = out_q.read;
    assign m0_write       = out_q.write;
    assign m0_debugaccess = out_q.debugaccess;

endmodule

// File: doc/avmm_mon_bridge.md
# avmm_mon_bridge

Parametrised Avalon-MM pipeline bridge with built-in traffic monitoring. It generalises the fixed 32-bit / 24-bit-address / single-beat debug bridge to configurable data, address and burst widths, and adds a bounded outstanding-read limit. Saturating transaction statistics and a read-response timeout flag are exposed for JTAG-side inspection. It sits between the JTAG master fabric (slave side `s0`) and the 10G BASE-R CSR space (master side `m0`).

## Interface
- DATA_W, 32: data width; multiple of 8.
- ADDR_W, 24: address width.
- BURST_W, 1: burstcount width; MAX_BURST = 2^(BURST_W-1).
- MAX_PENDING, 16: maximum outstanding read beats; must be ≥ MAX_BURST.
- CNT_W, 32: statistics counter width.
- TIMEOUT_CYC, 1024: read-response timeout in cycles.
- clk_clk  in  1  single clock.
- reset_reset_n  in  1  reset; **synchronous, active-low**.
- s0_address / s0_burstcount / s0_writedata / s0_byteenable  in  ADDR_W / BURST_W / DATA_W / DATA_W/8  slave command fields.
- s0_read, s0_write, s0_debugaccess  in  1 each  slave command strobes.
- s0_waitrequest  out  1  slave stall (registered).
- s0_readdata  out  DATA_W  read response data.
- s0_readdatavalid  out  1  read response valid.
- m0_address / m0_burstcount / m0_writedata / m0_byteenable / m0_read / m0_write / m0_debugaccess  out  as slave  forwarded command.
- m0_waitrequest  in  1  downstream stall.
- m0_readdata  in  DATA_W  downstream read data.
- m0_readdatavalid  in  1  downstream read valid.
- stat_clr  in  1  synchronous clear of all statistics.
- stat_wr_beats / stat_rd_cmds / stat_rd_beats  out  CNT_W each  accepted write beats, accepted read commands, returned read beats.
- stat_max_pending  out  clog2(MAX_PENDING+1)  high-water mark of pending read beats.
- stat_timeout  out  1  sticky read-timeout flag.

## Operation
- Command path: 2-entry buffer, consisting of an output register plus a skid register. A command is accepted when (s0_read|s0_write) & !s0_waitrequest. The output register drives m0_*. It advances when !m0_waitrequest or when it is empty (m0_read=m0_write=0).
- s0_waitrequest = skid_full | rd_throttle, both registered.
- rd_throttle = (pending_next > MAX_PENDING − MAX_BURST). It stalls writes as well as reads.
- Pending accounting: on read accept, pending += burstcount, with burstcount 0 counted as 1 but forwarded unchanged. On each s0_readdatavalid, pending −= 1. Simultaneous events net together. Pending saturates at 0; an unexpected beat never underflows it.
- Response path: m0_readdata/m0_readdatavalid are registered onto s0_readdata/s0_readdatavalid. There is no back-pressure.
- Counters saturate at all-ones and increment per event:
  - stat_wr_beats: per accepted write beat.
  - stat_rd_cmds: per accepted read command.
  - stat_rd_beats: per s0_readdatavalid.
- stat_max_pending = max(stat_max_pending, pending), updated every cycle.
- Timeout: the idle counter increments while pending≠0 and no s0_readdatavalid. It resets to 0 on s0_readdatavalid or when pending=0. When it reaches TIMEOUT_CYC, stat_timeout sets and stays set. Traffic is unaffected.
- stat_clr zeroes all stat_* and the idle counter next cycle. Clear wins over a simultaneous increment.

## Timing
- Reset (reset_reset_n=0 at a clock edge):
  - s0_waitrequest=1.
  - All other outputs 0.
  - Buffers emptied, pending=0, all statistics 0.
  - s0_waitrequest falls at the first edge with reset_reset_n=1.
- Reset mid-operation discards buffered commands and pending state. Later downstream beats are still forwarded and counted, with pending held at 0.
- Command latency: accept at edge N, visible on m0_* after edge N; 1 cycle with an empty buffer.
- Throughput: 1 command/cycle with m0_waitrequest=0.
- With m0_waitrequest held high, the bridge absorbs 2 commands, then s0_waitrequest=1 after the second accept edge.
- Response latency: exactly 1 cycle, m0_readdatavalid → s0_readdatavalid.
- All command fields are held stable on m0_* while m0_waitrequest=1.

## Test plan
- Reset release: hold reset_reset_n=0 for 3 cycles → s0_waitrequest=1 and all stats 0; waitrequest=0 one cycle after release.
- Back-pressure: 5 single writes with m0_waitrequest=1 for 10 cycles → exactly 2 accepted, then stall; all 5 appear on m0 in order with correct data/byteenable; stat_wr_beats=5.
- Burst throttle (BURST_W=3, MAX_PENDING=8): issue 4-beat reads with no responses → second read accepted and s0_waitrequest asserts until ≥4 beats return; stat_max_pending=8.
- Simultaneous accept and return: read accepted in the same cycle a beat returns with pending=3, burst=2 → pending=4; each beat emerges 1 cycle after m0_readdatavalid.
- Timeout (TIMEOUT_CYC=16): one read, no response → stat_timeout=1 at cycle 16; a late beat leaves it set; stat_clr clears it and zeroes counters, including with a concurrent write accept.
- Saturation and underflow (CNT_W=4): 20 writes → stat_wr_beats=15. Inject a stray m0_readdatavalid with pending=0 → forwarded, stat_rd_beats+1, pending stays 0.
